lsu_mem_port: RTL and testbench

Parametrised load/store memory port for the pipelined core. It sits between the memory stage (after the execute/memory pipeline register) and the external data memory, and replaces the single-cycle `read_in`/`write_out` path with a req/ack handshake. It supports word and byte accesses with sign or zero extension, and checks alignment. It stalls the pipeline while an access is outstanding and reports a bus timeout.

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_lane_align.sv | 41 ++++
 rtl/lsu_mem_port.sv | 193 +++++++++++++++++++
 tb/tb_lsu_mem_port.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory port.
// State encoding, access-size codes and the byte-enable generator.
package lsu_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    typedef enum logic {
        SizeWord = 1'b0,
        SizeByte = 1'b1
    } size_e;

    // Widest lane-enable vector the helper can produce; callers slice it.
    localparam int unsigned MaxBytes = 32;

    function automatic logic [MaxBytes-1:0] be_for(input int unsigned offset, input size_e size);
        logic [MaxBytes-1:0] be;
        if (size == SizeByte) begin
            be = MaxBytes'(1) << offset;
        end else begin
            be = '1;
        end
        return be;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane handling: store replication, byte-enable generation,
// and load lane extraction with zero/sign extension (little-endian lanes).
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    localparam int unsigned BYTES = DATA_W / 8,
    localparam int unsigned OFF_W = $clog2(BYTES)
) (
    input  logic [OFF_W-1:0]  offset,
    input  size_e             size,
    input  logic              sign_ext,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [DATA_W-1:0] rdata_in,
    output logic [BYTES-1:0]  be,
    output logic [DATA_W-1:0] wdata_out,
    output logic [DATA_W-1:0] rdata_out
);

    logic [MaxBytes-1:0] be_full;
    logic [7:0]          lane;

    always_comb begin
        be_full = be_for(int'(offset), size);
        be      = be_full[BYTES-1:0];

        if (size == SizeByte) begin
            wdata_out = {BYTES{wdata_in[7:0]}};
        end else begin
            wdata_out = wdata_in;
        end

        lane = rdata_in[{offset, 3'b000} +: 8];
        if (size == SizeByte) begin
            rdata_out = {{(DATA_W-8){sign_ext & lane[7]}}, lane};
        end else begin
            rdata_out = rdata_in;
        end
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store memory port: latches a memory-stage access, runs a req/ack
// handshake with a timeout, and returns a registered one-cycle response.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned RD_W    = 4,
    parameter int unsigned TIMEOUT = 255,
    localparam int unsigned BYTES  = DATA_W / 8,
    localparam int unsigned OFF_W  = $clog2(BYTES)
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [RD_W-1:0]   req_rd,
    output logic              stall,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [RD_W-1:0]   resp_rd,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BYTES-1:0]  mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              we_q;
    size_e             size_q;
    logic              signed_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [RD_W-1:0]   rd_q;

    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic [RD_W-1:0]   resp_rd_q, resp_rd_d;
    logic              resp_err_q, resp_err_d;

    logic              accept;
    logic              misaligned;
    logic              busy;
    logic [BYTES-1:0]  st_be;
    logic [DATA_W-1:0] st_wdata;
    logic [DATA_W-1:0] ld_rdata;
    logic [BYTES-1:0]  ld_be_unused;
    logic [DATA_W-1:0] ld_wdata_unused;
    logic [DATA_W-1:0] st_rdata_unused;

    assign accept     = (state_q == StIdle) && req_valid;
    assign misaligned = !req_byte && (req_addr[OFF_W-1:0] != '0);
    assign busy       = (state_q == StBusy);

    lsu_lane_align #(
        .DATA_W (DATA_W)
    ) u_store_align (
        .offset    (addr_q[OFF_W-1:0]),
        .size      (size_q),
        .sign_ext  (1'b0),
        .wdata_in  (wdata_q),
        .rdata_in  ('0),
        .be        (st_be),
        .wdata_out (st_wdata),
        .rdata_out (st_rdata_unused)
    );

    lsu_lane_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .offset    (addr_q[OFF_W-1:0]),
        .size      (size_q),
        .sign_ext  (signed_q),
        .wdata_in  ('0),
        .rdata_in  (mem_rdata),
        .be        (ld_be_unused),
        .wdata_out (ld_wdata_unused),
        .rdata_out (ld_rdata)
    );

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            size_q   <= SizeWord;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= '0;
        end else if (accept) begin
            we_q     <= req_write;
            size_q   <= req_byte ? SizeByte : SizeWord;
            signed_q <= req_signed;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            rd_q     <= req_rd;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_rd_q    <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_rd_q    <= resp_rd_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Response registers are only loaded on the transition into DONE, so they
    // read as zero in every other cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_rd_d    = '0;
        resp_err_d   = 1'b0;
        stall        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    stall = 1'b1;
                    cnt_d = '0;
                    if (misaligned) begin
                        state_d      = StDone;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rd_d    = req_rd;
                    end else begin
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                stall = 1'b1;
                if (mem_ack) begin
                    state_d      = StDone;
                    resp_valid_d = 1'b1;
                    resp_rd_d    = rd_q;
                    resp_rdata_d = we_q ? '0 : ld_rdata;
                end else if (cnt_q == CntLast) begin
                    state_d      = StDone;
                    resp_valid_d = 1'b1;
                    resp_rd_d    = rd_q;
                    resp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Memory-side outputs decode from state so a reset drops them immediately.
    assign mem_req   = busy;
    assign mem_we    = busy & we_q;
    assign mem_addr  = busy ? addr_q : '0;
    assign mem_be    = busy ? st_be : '0;
    assign mem_wdata = busy ? st_wdata : '0;

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_rd    = resp_rd_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port (DATA_W=16, TIMEOUT=4): directed
// scenarios plus randomized accesses against an arithmetic reference model.
module tb_lsu_mem_port;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 16;
    localparam int unsigned RW = 4;
    localparam int unsigned TO = 4;
    localparam int unsigned NB = DW / 8;

    logic          clock;
    logic          rst;
    logic          req_valid;
    logic          req_write;
    logic          req_byte;
    logic          req_signed;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [RW-1:0] req_rd;
    logic          stall;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic [RW-1:0] resp_rd;
    logic          resp_err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [NB-1:0] mem_be;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    lsu_mem_port #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .RD_W    (RW),
        .TIMEOUT (TO)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_byte   (req_byte),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_rd    (resp_rd),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One access; ack_at is the 1-based BUSY cycle of the ack, 0 for none.
    task automatic run_txn(input string name, input logic wr, input logic byt, input logic sgn,
                           input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [3:0] rd, input int ack_at, input logic [15:0] rdata);
        int unsigned off;
        int unsigned lane;
        int unsigned exp_be;
        int unsigned exp_wdata;
        int unsigned exp_rdata;
        int          exp_done;
        logic        exp_err;
        logic        mis;
        logic        seen;
        int          cyc;

        off  = addr % NB;
        mis  = !byt && (off != 0);
        exp_be    = byt ? (1 << off) : ((1 << NB) - 1);
        exp_wdata = byt ? (wdata & 8'hFF) * 16'h0101 : wdata;
        lane      = (rdata >> (8 * off)) & 8'hFF;
        if (wr) exp_rdata = 0;
        else if (!byt) exp_rdata = rdata;
        else if (sgn && lane >= 128) exp_rdata = lane + 16'hFF00;
        else exp_rdata = lane;
        if (mis) begin
            exp_done = 1; exp_err = 1'b1; exp_rdata = 0;
        end else if (ack_at >= 1 && ack_at <= int'(TO)) begin
            exp_done = ack_at + 1; exp_err = 1'b0;
        end else begin
            exp_done = TO + 1; exp_err = 1'b1; exp_rdata = 0;
        end

        req_write = wr; req_byte = byt; req_signed = sgn;
        req_addr = addr; req_wdata = wdata; req_rd = rd; req_valid = 1'b1;
        #1;
        check({name, " c0 stall"}, stall, 1);
        check({name, " c0 mem_req"}, mem_req, 0);
        step();
        req_valid = 1'b0;
        req_addr = AW'($urandom); req_wdata = DW'($urandom); req_rd = RW'($urandom);
        req_write = 1'($urandom); req_byte = 1'($urandom); req_signed = 1'($urandom);

        seen = 1'b0;
        cyc  = 1;
        while (cyc <= int'(TO) + 3 && !seen) begin
            if (resp_valid) begin
                seen = 1'b1;
                check({name, " resp cycle"}, cyc, exp_done);
                check({name, " resp_rdata"}, resp_rdata, exp_rdata);
                check({name, " resp_err"}, resp_err, exp_err);
                check({name, " resp_rd"}, resp_rd, rd);
                check({name, " done stall"}, stall, 0);
                check({name, " done mem_req"}, mem_req, 0);
            end else begin
                check({name, " busy stall"}, stall, 1);
                check({name, " busy mem_req"}, mem_req, !mis);
                check({name, " busy mem_be"}, mem_be, exp_be);
                check({name, " busy mem_we"}, mem_we, wr);
                check({name, " busy mem_addr"}, mem_addr, addr);
                check({name, " busy mem_wdata"}, mem_wdata, exp_wdata);
            end
            mem_ack   = (cyc == ack_at);
            mem_rdata = (cyc == ack_at) ? rdata : DW'($urandom);
            step();
            mem_ack = 1'b0;
            cyc++;
        end
        if (!seen) check({name, " resp seen"}, 0, 1);
        check({name, " after resp_valid"}, resp_valid, 0);
        check({name, " after stall"}, stall, 0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; req_rd = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        #12;
        check("reset stall", stall, 0);
        check("reset resp_valid", resp_valid, 0);
        check("reset resp_rdata", resp_rdata, 0);
        check("reset resp_rd", resp_rd, 0);
        check("reset resp_err", resp_err, 0);
        check("reset mem_req", mem_req, 0);
        check("reset mem_we", mem_we, 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset mem_be", mem_be, 0);
        check("reset mem_wdata", mem_wdata, 0);
        step();
        rst = 1'b0;
        step();

        run_txn("word load", 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 4'h5, 3, 16'hBEEF);
        run_txn("byte load s", 1'b0, 1'b1, 1'b1, 16'h0011, 16'h0000, 4'h3, 1, 16'h80AA);
        run_txn("byte load u", 1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000, 4'h3, 1, 16'h80AA);
        run_txn("byte store", 1'b1, 1'b1, 1'b0, 16'h0020, 16'h1234, 4'h7, 2, 16'hFFFF);
        run_txn("misaligned", 1'b1, 1'b0, 1'b0, 16'h0021, 16'h5678, 4'h9, 1, 16'h0000);
        run_txn("timeout", 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 4'hA, 0, 16'h0000);

        // Late ack one cycle after the timeout response must be dropped.
        mem_ack = 1'b1;
        mem_rdata = 16'hDEAD;
        #1;
        check("late ack mem_req", mem_req, 0);
        step();
        mem_ack = 1'b0;
        check("late ack resp_valid", resp_valid, 0);
        run_txn("after timeout", 1'b0, 1'b0, 1'b0, 16'h0042, 16'h0000, 4'hB, 2, 16'h1357);

        // Reset in the second BUSY cycle aborts the access.
        req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0;
        req_addr = 16'h0050; req_rd = 4'hC; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        check("pre-reset mem_req", mem_req, 1);
        rst = 1'b1;
        #1;
        check("reset mid mem_req", mem_req, 0);
        check("reset mid stall", stall, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_ack = 1'b1;
            step();
            check("post-reset resp_valid", resp_valid, 0);
            check("post-reset mem_req", mem_req, 0);
        end
        mem_ack = 1'b0;
        run_txn("after reset", 1'b0, 1'b1, 1'b1, 16'h0061, 16'h0000, 4'hD, 1, 16'h7F01);

        for (int n = 0; n < 40; n++) begin
            int gap;
            run_txn("random", 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
                    16'($urandom), 4'($urandom), int'($urandom_range(0, 6)), 16'($urandom));
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
